div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 16 +
 rtl/div.sv | 133 +++++++++++++
 tb/tb_div.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared constants for the divider (flag bit positions, iteration count, counter width)
package div_pkg;
    localparam int OVERFLOW  = 3;
    localparam int ZERO      = 2;
    localparam int SIGN      = 1;
    localparam int CARRY     = 0;
    localparam int DIV_CYCLE = 32;
    localparam int CNT_W     = $clog2(DIV_CYCLE + 2);
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration (shift in a dividend bit, subtract divisor if it fits)
module div_step (
    input  logic [32:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] d_i,
    output logic [32:0] rem_o,
    output logic        q_o
);
    logic [32:0] sh, diff;
    logic        unused_msb;
    assign unused_msb = rem_i[32];
    assign sh    = {rem_i[31:0], bit_i};
    assign diff  = sh - {1'b0, d_i};
    assign q_o   = sh >= {1'b0, d_i};
    assign rem_o = q_o ? diff : sh;
endmodule

// File: rtl/div.sv
// div: 32-bit restoring divider, 34-edge latency, {O,Z,S,C} flags; signed mode built only with DIV_SIGNED_EN
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        signed_op,
    input  logic [31:0] N_in,
    input  logic [31:0] D_in,
    output logic        done,
    output logic [31:0] Q_out,
    output logic [31:0] R_out,
    output logic [3:0]  flag
);
    cnt_t        count_q, count_d;
    logic [31:0] n_q, n_d, d_q, d_d, q_q, q_d, rout_q, rout_d;
    logic [32:0] r_q, r_d, step_r;
    logic        step_q, done_q, done_d, ov_q, ov_d, cy_q, cy_d, dz_q, dz_d;
    logic [31:0] n_mag, d_mag, q_fin, r_fin;
    logic        ov_fin;

    div_step u_step (
        .rem_i(r_q),
        .bit_i(n_q[31]),
        .d_i  (d_q),
        .rem_o(step_r),
        .q_o  (step_q)
    );

`ifdef DIV_SIGNED_EN
    logic [32:0] n_ext, d_ext, n_neg, d_neg;
    logic        negq_q, negr_q, ovp_q;
    assign n_ext  = {signed_op & N_in[31], N_in};
    assign d_ext  = {signed_op & D_in[31], D_in};
    assign n_neg  = -n_ext;
    assign d_neg  = -d_ext;
    assign n_mag  = n_ext[32] ? n_neg[31:0] : N_in;
    assign d_mag  = d_ext[32] ? d_neg[31:0] : D_in;
    // capture result signs and the -2^31/-1 overflow case at load
    always_ff @(posedge clk) begin
        if (reset) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            ovp_q  <= 1'b0;
        end else if (en && count_q == '0) begin
            negq_q <= n_ext[32] ^ d_ext[32];
            negr_q <= n_ext[32];
            ovp_q  <= signed_op && N_in == 32'h8000_0000 && D_in == 32'hFFFF_FFFF;
        end
    end
    assign q_fin  = negq_q ? -n_q : n_q;
    assign r_fin  = negr_q ? -r_q[31:0] : r_q[31:0];
    assign ov_fin = ovp_q;
`else
    logic unused_signed;
    assign unused_signed = signed_op;
    assign n_mag  = N_in;
    assign d_mag  = D_in;
    assign q_fin  = n_q;
    assign r_fin  = r_q[31:0];
    assign ov_fin = 1'b0;
`endif

    // counter sequencing: load at 0, iterate 1..32, publish result at 33; en low aborts
    always_comb begin
        count_d = count_q;
        n_d     = n_q;
        d_d     = d_q;
        r_d     = r_q;
        dz_d    = dz_q;
        q_d     = q_q;
        rout_d  = rout_q;
        ov_d    = ov_q;
        cy_d    = cy_q;
        done_d  = 1'b0;
        if (!en) begin
            count_d = '0;
        end else if (count_q == '0) begin
            count_d = cnt_t'(1);
            n_d     = n_mag;
            d_d     = d_mag;
            r_d     = '0;
            dz_d    = D_in == '0;
        end else if (count_q <= cnt_t'(DIV_CYCLE)) begin
            count_d = count_q + cnt_t'(1);
            n_d     = {n_q[30:0], step_q};
            r_d     = step_r;
        end else begin
            count_d = '0;
            done_d  = 1'b1;
            q_d     = dz_q ? '1 : q_fin;
            rout_d  = r_fin;
            ov_d    = ov_fin;
            cy_d    = dz_q;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            n_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            rout_q  <= '0;
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            n_q     <= n_d;
            d_q     <= d_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            rout_q  <= rout_d;
            ov_q    <= ov_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
        end
    end

    assign done           = done_q;
    assign Q_out          = q_q;
    assign R_out          = rout_q;
    assign flag[OVERFLOW] = ov_q;
    assign flag[ZERO]     = q_q == '0;
    assign flag[SIGN]     = q_q[31];
    assign flag[CARRY]    = cy_q;
endmodule

// File: tb/tb_div.sv
// tb_div: directed scoreboard bench for div; expectations pushed at issue, checked when done pulses
module tb_div;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  f;
        int          c;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, en = 1'b0, signed_op = 1'b0;
    logic [31:0] N_in = '0, D_in = '0;
    logic        done;
    logic [31:0] Q_out, R_out;
    logic [3:0]  flag;
    int          cyc = 0, checks = 0, fails = 0;
    exp_t        sb[$];

    div dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .signed_op(signed_op),
        .N_in     (N_in),
        .D_in     (D_in),
        .done     (done),
        .Q_out    (Q_out),
        .R_out    (R_out),
        .flag     (flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] n, input logic [31:0] d, input logic s, input bit push,
                         input logic [31:0] eq, input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        en = 1'b1;
        N_in = n;
        D_in = d;
        signed_op = s;
        if (push) begin
            e.q = eq;
            e.r = er;
            e.f = ef;
            e.c = cyc + 34;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 40);
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", k);
        end
    endtask

    task automatic op(input logic [31:0] n, input logic [31:0] d, input logic s,
                      input logic [31:0] eq, input logic [31:0] er, input logic [3:0] ef);
        issue(n, d, s, 1'b1, eq, er, ef);
        wait_done();
        en = 1'b0;
        @(negedge clk);
    endtask

    // monitor: every done pulse must match the oldest expectation, including its cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL stray_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("Q_out", Q_out, e.q);
                    chk("R_out", R_out, e.r);
                    chk("flag", {28'd0, flag}, {28'd0, e.f});
                    chk("done_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_Q", Q_out, 32'd0);
        chk("reset_R", R_out, 32'd0);
        chk("reset_flag", {28'd0, flag}, 32'b0100);
        chk("reset_done", {31'd0, done}, 32'd0);

        op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0000);
`ifdef DIV_SIGNED_EN
        op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 4'b0010);
`else
        op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'h2492_4916, 32'd2, 4'b0000);
`endif
        op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 4'b0011);
`ifdef DIV_SIGNED_EN
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 4'b1010);
`else
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 4'b0100);
`endif
        op(32'd6, 32'd3, 1'b0, 32'd2, 32'd0, 4'b0000);

        issue(32'd1000, 32'd3, 1'b0, 1'b0, '0, '0, '0);
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_Q", Q_out, 32'd2);
        chk("abort_R", R_out, 32'd0);

        op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 4'b0000);

        issue(32'd1000, 32'd7, 1'b0, 1'b0, '0, '0, '0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_Q", Q_out, 32'd0);
        chk("mid_reset_R", R_out, 32'd0);
        chk("mid_reset_flag", {28'd0, flag}, 32'b0100);
        repeat (40) @(negedge clk);

        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 4'b0000);
        wait_done();
        issue(32'd0, 32'd5, 1'b0, 1'b1, 32'd0, 32'd0, 4'b0100);
        wait_done();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 4'b0010);
        wait_done();
        en = 1'b0;
        repeat (5) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
